// File: rtl/btb_assoc_if.sv
// Signal bundle between the fetch/resolve logic and the set-associative BTB.
// update_en and flush are single-cycle strobes sampled at every rising edge; there is no backpressure.
interface btb_assoc_if;
    logic [31:0] PC;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] actual_target;
    logic        actual_taken;
    logic        flush;
    logic [31:0] predicted_target;
    logic        hit;
    logic        predicted_taken;
    logic        busy;
    logic        state_dbg;

    modport master (
        output PC, update_en, update_pc, actual_target, actual_taken, flush,
        input  predicted_target, hit, predicted_taken, busy, state_dbg
    );

    modport slave (
        input  PC, update_en, update_pc, actual_target, actual_taken, flush,
        output predicted_target, hit, predicted_taken, busy, state_dbg
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit counters, round-robin victim
// selection and a one-set-per-cycle flush walk.
module btb_assoc #(
    parameter int         SETS     = 64,
    parameter int         WAYS     = 2,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic         clk,
    input  logic         reset,
    btb_assoc_if.slave   bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   flush_cnt_q;

    logic               valid_q  [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q    [SETS][WAYS];
    logic [31:0]        target_q [SETS][WAYS];
    logic [1:0]         ctr_q    [SETS][WAYS];
    logic [WAY_W-1:0]   victim_q [SETS];

    logic [IDX_W-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               lk_hit;
    logic [31:0]        lk_target;
    logic [1:0]         lk_ctr;
    logic               up_hit, inv_found;
    logic [WAY_W-1:0]   up_way, inv_way, alloc_way, next_victim;
    logic               unused_low_bits;

    assign lk_idx = bus.PC[IDX_W+1:2];
    assign lk_tag = bus.PC[31:IDX_W+2];
    assign up_idx = bus.update_pc[IDX_W+1:2];
    assign up_tag = bus.update_pc[31:IDX_W+2];
    assign unused_low_bits = ^{bus.PC[1:0], bus.update_pc[1:0]};

    // Fetch-side lookup; at most one way can match because allocation only happens on a miss.
    always_comb begin
        lk_hit    = 1'b0;
        lk_target = '0;
        lk_ctr    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                lk_hit    = 1'b1;
                lk_target = target_q[lk_idx][w];
                lk_ctr    = ctr_q[lk_idx][w];
            end
        end
    end

    always_comb begin
        up_hit    = 1'b0;
        up_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!up_hit && valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[up_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign alloc_way   = inv_found ? inv_way : victim_q[up_idx];
    assign next_victim = (victim_q[up_idx] == WAY_W'(WAYS - 1)) ? '0 : victim_q[up_idx] + 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.flush) state_d = FLUSH;
            FLUSH:   if (flush_cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 1'b1 : '0;
        end
    end

    // Tag and target arrays are left out of reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    ctr_q[s][w]   <= 2'b00;
                end
                victim_q[s] <= '0;
            end
        end else if (state_q == FLUSH) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[flush_cnt_q][w] <= 1'b0;
            end
        end else if (bus.update_en) begin
            if (up_hit) begin
                if (bus.actual_taken) begin
                    target_q[up_idx][up_way] <= bus.actual_target;
                    if (ctr_q[up_idx][up_way] != 2'b11)
                        ctr_q[up_idx][up_way] <= ctr_q[up_idx][up_way] + 2'b01;
                end else if (ctr_q[up_idx][up_way] != 2'b00) begin
                    ctr_q[up_idx][up_way] <= ctr_q[up_idx][up_way] - 2'b01;
                end
            end else if (bus.actual_taken) begin
                valid_q[up_idx][alloc_way]  <= 1'b1;
                tag_q[up_idx][alloc_way]    <= up_tag;
                target_q[up_idx][alloc_way] <= bus.actual_target;
                ctr_q[up_idx][alloc_way]    <= CTR_INIT;
                if (!inv_found) victim_q[up_idx] <= next_victim;
            end
        end
    end

    assign bus.busy             = (state_q == FLUSH);
    assign bus.hit              = !bus.busy && lk_hit;
    assign bus.predicted_taken  = bus.hit && lk_ctr[1];
    assign bus.predicted_target = bus.hit ? lk_target : 32'h0;
    assign bus.state_dbg        = state_q;
endmodule
